// File: rtl/cic_decimator_pkg.sv
// Sizing and ratio helpers shared by the CIC decimator, its comb stages and its bus interface.
package cic_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Worst-case bit growth of an N-stage CIC: log2((R*M)^N) bits on top of the input.
    function automatic int acc_width(input int w_in, input int n, input int r_max, input int m);
        return w_in + n * clog2(r_max * m);
    endfunction

    function automatic int clamp_ratio(input int ratio, input int r_max);
        if (ratio == 0 || ratio > r_max) begin
            return r_max;
        end
        return ratio;
    endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-in / decimated-sample-out bus of the CIC decimator.
interface cic_decimator_if #(
    parameter int W_IN    = 8,
    parameter int W_OUT   = 14,
    parameter int W_RATIO = 3
);
    logic signed [W_IN-1:0]  i_data;
    logic                    i_ready;
    logic [W_RATIO-1:0]      i_ratio;
    logic signed [W_OUT-1:0] o_data;
    logic                    o_ready;

    modport master (
        output i_data,
        output i_ready,
        output i_ratio,
        input  o_data,
        input  o_ready
    );

    modport slave (
        input  i_data,
        input  i_ready,
        input  i_ratio,
        output o_data,
        output o_ready
    );
endinterface

// File: rtl/cic_decimator_comb_stage.sv
// One CIC comb (differentiator) stage running at the decimated rate, advanced only on tick.
module cic_comb_stage #(
    parameter int W_ACC = 14,
    parameter int M     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic signed [W_ACC-1:0] feed,
    output logic signed [W_ACC-1:0] diff
);
    logic signed [W_ACC-1:0] dly_p1 [M];

    // Difference against the sample M decimated periods back; wraps modulo 2^W_ACC.
    assign diff = feed - dly_p1[M-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                dly_p1[i] <= '0;
            end
        end else if (tick) begin
            dly_p1[0] <= feed;
            for (int i = 1; i < M; i++) begin
                dly_p1[i] <= dly_p1[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at the input rate, run-time ratio up to R_MAX,
// comb chain and truncating output register at the decimated rate.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int N     = 3,
    parameter int R_MAX = 4,
    parameter int M     = 1,
    parameter int W_OUT = acc_width(W_IN, N, R_MAX, M)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    cic_decimator_if.slave bus
);
    localparam int W_ACC   = acc_width(W_IN, N, R_MAX, M);
    localparam int W_RATIO = clog2(R_MAX + 1);

    // Keep the top W_OUT bits: arithmetic shift right by W_ACC-W_OUT, no rounding.
    function automatic logic signed [W_OUT-1:0] truncate(input logic signed [W_ACC-1:0] value);
        return value[W_ACC-1 -: W_OUT];
    endfunction

    logic signed [W_ACC-1:0] sample_ext;
    logic signed [W_ACC-1:0] integ_p0 [1:N];
    logic [W_RATIO-1:0]      phase_p0;
    logic [W_RATIO-1:0]      ratio_p0;
    logic                    tick;
    logic signed [W_ACC-1:0] comb_out;
    logic signed [W_OUT-1:0] data_p1;
    logic                    vld_p1;

    assign sample_ext = W_ACC'($signed(bus.i_data));

    // ---- stage p0: integrators and phase counter at the input rate ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 1; k <= N; k++) begin
                integ_p0[k] <= '0;
            end
        end else if (bus.i_ready) begin
            integ_p0[1] <= integ_p0[1] + sample_ext;
            for (int k = 2; k <= N; k++) begin
                integ_p0[k] <= integ_p0[k] + integ_p0[k-1];
            end
        end
    end

    assign tick = bus.i_ready && (phase_p0 == ratio_p0 - W_RATIO'(1));

    // The requested ratio only takes over at a period boundary, so a period is never cut short.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_p0 <= '0;
            ratio_p0 <= W_RATIO'(R_MAX);
        end else if (tick) begin
            phase_p0 <= '0;
            ratio_p0 <= W_RATIO'(clamp_ratio(int'(bus.i_ratio), R_MAX));
        end else if (bus.i_ready) begin
            phase_p0 <= phase_p0 + W_RATIO'(1);
        end
    end

    // ---- comb chain: combinational difference path, delay lines advance on tick ----
    for (genvar k = 0; k < N; k++) begin : g_comb
        logic signed [W_ACC-1:0] stage_feed;
        logic signed [W_ACC-1:0] stage_diff;

        if (k == 0) begin : g_first
            assign stage_feed = integ_p0[N];
        end else begin : g_next
            assign stage_feed = g_comb[k-1].stage_diff;
        end

        cic_comb_stage #(
            .W_ACC (W_ACC),
            .M     (M)
        ) u_stage (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .tick  (tick),
            .feed  (stage_feed),
            .diff  (stage_diff)
        );
    end

    assign comb_out = g_comb[N-1].stage_diff;

    // ---- stage p1: output register, strobed the cycle after each tick ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= tick;
            if (tick) begin
                data_p1 <= truncate(comb_out);
            end
        end
    end

    assign bus.o_data  = data_p1;
    assign bus.o_ready = vld_p1;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: a full-width and an 8-bit-output instance share stimulus.
module tb_cic_decimator;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cic_decimator_if #(.W_IN(8), .W_OUT(14), .W_RATIO(3)) bus_a ();
    cic_decimator_if #(.W_IN(8), .W_OUT(8),  .W_RATIO(3)) bus_b ();

    cic_decimator #(.W_IN(8), .N(3), .R_MAX(4), .M(1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    cic_decimator #(.W_IN(8), .N(3), .R_MAX(4), .M(1), .W_OUT(8)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    int   total;
    int   bad;
    int   exp_q [$];
    int   last_a;
    int   last_b;
    int   phase_cnt;
    int   ratio_cur;
    logic tick_exp   = 1'b0;
    logic strobe_exp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_bus(input int value, input bit valid, input int req);
        bus_a.i_data  = 8'(value);
        bus_b.i_data  = 8'(value);
        bus_a.i_ready = valid;
        bus_b.i_ready = valid;
        bus_a.i_ratio = 3'(req);
        bus_b.i_ratio = 3'(req);
    endtask

    // One input cycle; the bench tracks where each decimation period ends.
    task automatic drive(input int value, input bit valid, input int req);
        @(negedge clk);
        set_bus(value, valid, req);
        tick_exp = valid && (phase_cnt == ratio_cur - 1);
        if (valid) begin
            if (tick_exp) begin
                phase_cnt = 0;
                ratio_cur = (req == 0 || req > 4) ? 4 : req;
            end else begin
                phase_cnt++;
            end
        end
    endtask

    task automatic feed(input int value, input int count, input int gap, input int req);
        for (int s = 0; s < count; s++) begin
            for (int g = 0; g < gap; g++) begin
                drive(value, 1'b0, req);
            end
            drive(value, 1'b1, req);
        end
    endtask

    task automatic clear_model();
        set_bus(0, 1'b0, 4);
        tick_exp  = 1'b0;
        phase_cnt = 0;
        ratio_cur = 4;
        last_a    = 0;
        last_b    = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            drive(0, 1'b0, 4);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) drive(0, 1'b0, 4);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) strobe_exp <= 1'b0;
        else        strobe_exp <= tick_exp;
    end

    // Monitor: strobe timing every cycle, scoreboard pop on strobe, hold between strobes.
    initial begin
        int v;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                check("strobe", bus_a.o_ready, strobe_exp);
                check("strobe_trunc", bus_b.o_ready, strobe_exp);
                if (bus_a.o_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %0d, expected no strobe", bus_a.o_data);
                    end else begin
                        v = exp_q.pop_front();
                        check("data", bus_a.o_data, v);
                        check("data_trunc", bus_b.o_data, v >>> 6);
                        last_a = v;
                        last_b = v >>> 6;
                    end
                end else begin
                    check("hold", bus_a.o_data, last_a);
                    check("hold_trunc", bus_b.o_data, last_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        clear_model();
        #1 rst_n = 1'b0;
        #2;
        check("reset_data", bus_a.o_data, 0);
        check("reset_ready", bus_a.o_ready, 0);
        check("reset_data_trunc", bus_b.o_data, 0);
        check("reset_ready_trunc", bus_b.o_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // DC 1 at ratio 4: gain 64
        exp_q = '{1, 32, 63, 64, 64, 64};
        feed(1, 24, 0, 4);
        wait_drain();

        apply_reset();
        exp_q = '{-128, -4096, -8064, -8192, -8192};
        feed(-128, 20, 0, 4);
        wait_drain();

        apply_reset();
        exp_q = '{127, 4064, 8001, 8128};
        feed(127, 16, 0, 4);
        wait_drain();

        apply_reset();
        exp_q = '{100, 3200, 6300, 6400};
        feed(100, 16, 0, 4);
        wait_drain();

        apply_reset();
        exp_q = '{-100, -3200, -6300, -6400};
        feed(-100, 16, 0, 4);
        wait_drain();

        // Impulse: taps 0, 4 and 8 of the length-10 response
        apply_reset();
        exp_q = '{1, 12, 3, 0, 0, 0};
        drive(1, 1'b1, 4);
        feed(0, 23, 0, 4);
        wait_drain();

        // Gapped input: same sequence as continuous DC 1
        apply_reset();
        exp_q = '{1, 32, 63, 64, 64};
        feed(1, 20, 2, 4);
        wait_drain();

        // Ratio 2 requested from the start: first period still 4
        apply_reset();
        exp_q = '{1, 7, 8, 8, 8, 8};
        feed(1, 14, 0, 2);
        wait_drain();

        apply_reset();
        exp_q = '{1, 1, 1, 1, 1, 1, 1};
        feed(1, 10, 0, 1);
        wait_drain();

        apply_reset();
        exp_q = '{1, 32, 63, 64, 64, 64};
        feed(1, 24, 0, 7);
        wait_drain();

        apply_reset();
        exp_q = '{1, 32, 63, 64, 64, 64};
        feed(1, 24, 0, 0);
        wait_drain();

        // Reset two samples into a period
        apply_reset();
        exp_q = '{1, 32};
        feed(1, 8, 0, 4);
        wait_drain();
        feed(1, 2, 0, 4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_data", bus_a.o_data, 0);
        check("midreset_ready", bus_a.o_ready, 0);
        check("midreset_data_trunc", bus_b.o_data, 0);
        check("midreset_ready_trunc", bus_b.o_ready, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q = '{1};
        feed(1, 4, 0, 4);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Parametrised N-stage cascaded integrator-comb (CIC) decimator, the successor to the fixed keep-one-in-R sample decimator in the CIC filter path. Accepts signed samples qualified by `i_ready`, integrates at the input rate, decimates by a run-time-selectable ratio up to `R_MAX`, and combs and scales at the output rate. It sits between the sample source and the downstream output-rate consumer, presenting one strobed word per decimated sample.

## Interface
- `W_IN`, 8: input sample width, signed two's complement.
- `N`, 3: number of integrator and comb stages, 1..6.
- `R_MAX`, 4: maximum decimation ratio, ≥1; also the reset-time ratio.
- `M`, 1: differential delay of each comb, 1 or 2.
- `W_ACC`, `W_IN + N*clog2(R_MAX*M)`: internal accumulator width; derived, never overridden.
- `W_OUT`, `W_ACC`: output width, ≤ `W_ACC`.
- `i_clk`  in  1  single clock; all state on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  `W_IN`  signed input sample, valid when `i_ready`=1.
- `i_ready`  in  1  input-sample qualifier; one sample per high cycle.
- `i_ratio`  in  `clog2(R_MAX+1)`  requested decimation ratio.
- `o_data`  out  `W_OUT`  signed decimated sample.
- `o_ready`  out  1  one-cycle strobe: `o_data` is new this cycle.

## Operation
- Reset (async assert, sync release): integrators, comb delay lines, phase counter, `o_data` and `o_ready` all 0; active ratio register = `R_MAX`.
- Integrators: `I_0` = `i_data` sign-extended to `W_ACC`; on each `i_ready` cycle, `I_k <= I_k + I_(k-1)` for k=1..N, each from the registered value of the previous stage. Idle cycles hold all state.
- All arithmetic is modulo 2^`W_ACC` two's-complement; integrator wrap is intentional and must not saturate.
- Phase counter counts accepted samples only. Tick = `i_ready` & counter == active ratio − 1; on tick the counter returns to 0, otherwise it increments on `i_ready`.
- On tick: comb input `C_0` = registered `I_N` (pre-update value); `C_k = C_(k-1) − D_k[M-1]` combinationally, and each stage's M-deep delay line shifts in `C_(k-1)`; `o_data` <= top `W_OUT` bits of `C_N` (truncation, arithmetic shift right by `W_ACC−W_OUT`, no rounding).
- Ratio change: `i_ratio` is sampled only on tick and becomes the active ratio for the next period. Value 0 or > `R_MAX` is clamped to `R_MAX`. Ratio 1 is legal: every accepted sample produces an output.
- Gain is (ratio·M)^N before truncation; at ratio < `R_MAX`, output magnitude is correspondingly lower (no re-normalisation).

## Timing
- `o_ready` is high exactly the cycle after a tick and low otherwise; with ratio ≥2, never high two cycles in a row.
- Ratio 1 with `i_ready` held high gives `o_ready` continuously high.
- First `o_ready` after reset release follows the `R_MAX`-th accepted sample.
- Gaps in `i_ready` stretch timing but never change the `o_data` sequence.
- `o_data` holds its value between strobes.
- Reset asserted mid-period: outputs drop to 0 immediately, partial period discarded.

## Structure
- Package `cic_pkg`: `clog2` function, `W_ACC` bit-growth function of (`W_IN`, `N`, `R_MAX`, `M`), ratio-clamp function.
- Sub-module `cic_comb_stage` (parameters `W_ACC`, `M`): one differential stage with its M-deep delay line and tick enable, generated N times. Integrators stay inline.

## Test plan
All with `W_IN`=8, `N`=3, `R_MAX`=4, `M`=1, `W_ACC`=`W_OUT`=14 unless stated.
- DC: `i_data`=1 every cycle, `i_ratio`=4 → `o_ready` every 4th cycle; `o_data` settles to 64; `i_data`=−128 → −8192; 127 → 8128.
- Impulse: single 1 then zeros → nonzero `o_data` for at most 4 strobes, summing to 16; all later outputs 0.
- Gapped input: same DC stimulus with `i_ready` high every 3rd cycle → identical `o_data` sequence; `o_ready` one cycle after every 4th accepted sample.
- Ratio change and clamp: `i_ratio`=2 → switch takes effect on the next period; DC 1 settles to 8. `i_ratio`=0 or 7 behaves as 4; `i_ratio`=1 → `o_ready` every cycle.
- Truncation (`W_OUT`=8): DC 1 → 1; DC 100 → 100; DC −100 → −100.
- Reset mid-period: `i_rst_n` low after 2 accepted samples → `o_data`=0 and `o_ready`=0 asynchronously; after release, first strobe after exactly 4 new accepted samples.
